mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i, rst_i.
REQ-002 clk_i  input  1  rising-edge clock for all state.
REQ-003 rst_i  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  request a new operation; sampled only when idle.
REQ-005 op_i  input  2  00 MULTU, 01 DIVU, 10 MULT (signed), 11 DIV (signed).
REQ-006 src1_i  input  32  multiplicand / dividend, the same operand bus that feeds the ALU.
REQ-007 src2_i  input  32  multiplier / divisor, the same operand bus that feeds the ALU.
REQ-008 hi_o  output  32  HI register: product[63:32] or remainder.
REQ-009 lo_o  output  32  LO register: product[31:0] or quotient.
REQ-010 busy_o  output  1  high while an operation is in progress.
REQ-011 done_o  output  1  one-cycle pulse; hi_o and lo_o updated on the same edge.
REQ-012 dz_o  output  1  divide-by-zero flag for the last completed operation.

Function
REQ-013 States SHALL be IDLE, CALC and FIX; busy_o = (state != IDLE).
REQ-014 IDLE with start_i=1 at edge E0 SHALL latch op_i, src1_i and src2_i, and SHALL go to CALC with the iteration counter at 0.
REQ-015 start_i while busy_o=1 SHALL be ignored; operand changes after E0 SHALL NOT affect the result.
REQ-016 CALC SHALL perform one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-017 CALC SHALL run exactly 32 iterations (edges E1..E32), then go to FIX.
REQ-018 FIX at edge E33 SHALL apply the sign correction, write hi_o and lo_o, set done_o=1, and return to IDLE.
REQ-019 busy_o SHALL be high from after E0 until E33, i.e. 33 cycles.
REQ-020 done_o SHALL be high for exactly the one cycle after E33.
REQ-021 start_i=1 during the done_o cycle SHALL be accepted as a new E0.
REQ-022 Signed operations SHALL operate on magnitudes and negate the results in FIX.
REQ-023 For signed operations, the product sign SHALL be the XOR of the operand signs.
REQ-024 For signed operations, the quotient sign SHALL be the XOR of the operand signs and the remainder sign SHALL follow the dividend.
REQ-025 MULTU and MULT SHALL produce the full 64-bit product {hi_o, lo_o} with no truncation.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL wrap to lo_o=0x80000000, hi_o=0, dz_o=0.
REQ-027 Divide with src2=0 at E0 SHALL skip CALC: go to FIX, write hi_o=src1 and lo_o=0xFFFFFFFF, set dz_o=1, and pulse done_o after E1.
REQ-028 dz_o SHALL be cleared when the next operation completes without divide-by-zero.
REQ-029 Outside the done edge, hi_o and lo_o SHALL hold their values; an aborted operation SHALL NOT modify them.

Reset
REQ-030 rst_i=1 at a clock edge SHALL force state=IDLE and the counter to 0.
REQ-031 rst_i=1 at a clock edge SHALL force hi_o=0, lo_o=0, busy_o=0, done_o=0 and dz_o=0.
REQ-032 Reset mid-CALC SHALL abort the operation with no done_o pulse; start_i in the same cycle as reset SHALL be ignored.
REQ-033 The first operation after reset deasserts SHALL be acceptable on the next edge.

Verification
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o 34 cycles after the start cycle, hi_o=0xFFFFFFFE, lo_o=0x00000001, dz_o=0.
REQ-035 MULT 0xFFFFFFFD(-3) x 7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; DIV -7 / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-036 DIVU 100 / 0 -> done_o after 2 cycles, hi_o=100, lo_o=0xFFFFFFFF, dz_o=1; then DIVU 100 / 7 -> lo_o=14, hi_o=2, dz_o=0.
REQ-037 Start DIVU 50/5; pulse start_i with new operands at cycle 10; change src1_i mid-run -> lo_o=10, hi_o=0, exactly one done_o.
REQ-038 Start MULTU 3x4; assert rst_i at cycle 15 -> busy_o=0, no done_o, hi_o=lo_o=0; a new MULTU 3x4 completes with lo_o=12.
REQ-039 Back-to-back: start_i held high continuously -> a new operation is accepted every 34 cycles, each with a one-cycle done_o.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// with signed operations done on magnitudes and corrected in a final FIX cycle.
module mul_div_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] src1_i,
    input  logic [31:0] src2_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        dz_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        div_q, div_d;
    logic        neg_lo_q, neg_lo_d;
    logic        neg_hi_q, neg_hi_d;
    logic        dzp_q, dzp_d;
    logic [31:0] opd_q, opd_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;
    logic        dz_q, dz_d;

    logic        s1_neg_s;
    logic        s2_neg_s;
    logic [32:0] mul_sum_s;
    logic [32:0] div_sh_s;
    logic [32:0] div_diff_s;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign s1_neg_s   = op_i[1] & src1_i[31];
    assign s2_neg_s   = op_i[1] & src2_i[31];
    // Multiply keeps {partial product, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
    assign mul_sum_s  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opd_q} : 33'd0);
    assign div_sh_s   = {acc_q[63:32], acc_q[31]};
    assign div_diff_s = div_sh_s - {1'b0, opd_q};

    // Next-state, datapath step and result write-back.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dzp_d    = dzp_q;
        opd_d    = opd_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    div_d = op_i[0];
                    cnt_d = 6'd0;
                    if (op_i[0] && (src2_i == 32'd0)) begin
                        acc_d    = {src1_i, 32'hFFFF_FFFF};
                        opd_d    = 32'd0;
                        neg_lo_d = 1'b0;
                        neg_hi_d = 1'b0;
                        dzp_d    = 1'b1;
                        state_d  = FIX;
                    end else begin
                        neg_lo_d = s1_neg_s ^ s2_neg_s;
                        neg_hi_d = s1_neg_s;
                        dzp_d    = 1'b0;
                        state_d  = CALC;
                        if (op_i[0]) begin
                            acc_d = {32'd0, mag32(src1_i, op_i[1])};
                            opd_d = mag32(src2_i, op_i[1]);
                        end else begin
                            acc_d = {32'd0, mag32(src2_i, op_i[1])};
                            opd_d = mag32(src1_i, op_i[1]);
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (div_q) begin
                    if (!div_diff_s[32]) begin
                        acc_d = {div_diff_s[31:0], acc_q[30:0], 1'b1};
                    end else begin
                        acc_d = {div_sh_s[31:0], acc_q[30:0], 1'b0};
                    end
                end else begin
                    acc_d = {mul_sum_s, acc_q[31:1]};
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end else begin
                    state_d = CALC;
                end
            end
            FIX: begin
                if (div_q) begin
                    lo_d = neg_lo_q ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
                    hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
                end else begin
                    {hi_d, lo_d} = neg_lo_q ? (64'd0 - acc_q) : acc_q;
                end
                done_d  = 1'b1;
                dz_d    = dzp_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dzp_q    <= 1'b0;
            opd_q    <= 32'd0;
            acc_q    <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dzp_q    <= dzp_d;
            opd_q    <= opd_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;
    assign dz_o   = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model checked every cycle, plus hand-computed literals.
module tb_mul_div_unit;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i    = 2'd0;
    logic [31:0] src1_i  = 32'd0;
    logic [31:0] src2_i  = 32'd0;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o, dz_o;

    mul_div_unit dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(start_i),
        .op_i   (op_i),
        .src1_i (src1_i),
        .src2_i (src2_i),
        .hi_o   (hi_o),
        .lo_o   (lo_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .dz_o   (dz_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Returns {dz, hi, lo} straight from integer arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: begin
                p = {32'd0, a} * {32'd0, b};
                return {1'b0, p};
            end
            2'd2: begin
                p = sa * sb;
                return {1'b0, p};
            end
            2'd1: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    // Model: an accepted operation finishes 33 edges later (1 for divide-by-zero).
    int          m_left = 0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic        m_dz = 1'b0, m_done = 1'b0, p_dz = 1'b0;
    bit          chk_en = 1'b0;

    always @(posedge clk_i) begin
        chk_en <= 1'b1;
        if (rst_i) begin
            m_left <= 0;
            m_hi   <= 32'd0;
            m_lo   <= 32'd0;
            m_dz   <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_dz   <= p_dz;
                    m_done <= 1'b1;
                end
            end else if (start_i) begin
                {p_dz, p_hi, p_lo} <= ref_op(op_i, src1_i, src2_i);
                m_left <= (op_i[0] && (src2_i == 32'd0)) ? 1 : 33;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            n_vec++;
            if ({busy_o, done_o, dz_o, hi_o, lo_o} !== {(m_left > 0), m_done, m_dz, m_hi, m_lo}) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dz=%b hi=%h lo=%h expected busy=%b done=%b dz=%b hi=%h lo=%h",
                         $time, busy_o, done_o, dz_o, hi_o, lo_o, (m_left > 0), m_done, m_dz, m_hi, m_lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Issues one operation and returns edges until done_o is seen (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
        start_i = 1'b1;
        op_i    = op;
        src1_i  = a;
        src2_i  = b;
        tick();
        lat     = 1;
        start_i = 1'b0;
        while (done_o !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        if (lat >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL timeout: no done_o within %0d cycles", lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int dones;
        int t_done[$];
        logic [31:0] s_hi, s_lo;

        repeat (3) tick();
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);
        check("reset_flags", {29'd0, busy_o, done_o, dz_o}, 32'd0);
        rst_i = 1'b0;

        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("multu_lat", lat, 32'd34);
        check("multu_hi", hi_o, 32'hFFFF_FFFE);
        check("multu_lo", lo_o, 32'h0000_0001);
        check("multu_dz", {31'd0, dz_o}, 32'd0);

        run_op(2'd2, 32'hFFFF_FFFD, 32'd7, lat);
        check("mult_hi", hi_o, 32'hFFFF_FFFF);
        check("mult_lo", lo_o, 32'hFFFF_FFEB);

        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, lat);
        check("div_lo", lo_o, 32'hFFFF_FFFD);
        check("div_hi", hi_o, 32'hFFFF_FFFF);

        run_op(2'd1, 32'd100, 32'd0, lat);
        check("dz_lat", lat, 32'd2);
        check("dz_hi", hi_o, 32'd100);
        check("dz_lo", lo_o, 32'hFFFF_FFFF);
        check("dz_flag", {31'd0, dz_o}, 32'd1);

        run_op(2'd1, 32'd100, 32'd7, lat);
        check("divu_lo", lo_o, 32'd14);
        check("divu_hi", hi_o, 32'd2);
        check("divu_dz_clr", {31'd0, dz_o}, 32'd0);

        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, lat);
        check("div_wrap_lo", lo_o, 32'h8000_0000);
        check("div_wrap_hi", hi_o, 32'd0);

        run_op(2'd2, 32'h8000_0000, 32'h8000_0000, lat);
        check("mult_min_hi", hi_o, 32'h4000_0000);
        check("mult_min_lo", lo_o, 32'd0);

        // Model-only vectors.
        run_op(2'd0, 32'h1234_5678, 32'h9ABC_DEF0, lat);
        run_op(2'd3, 32'd7, 32'hFFFF_FFFE, lat);
        run_op(2'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, lat);
        run_op(2'd1, 32'hFFFF_FFFF, 32'd1, lat);
        run_op(2'd1, 32'd5, 32'd10, lat);
        run_op(2'd3, 32'd9, 32'd0, lat);
        tick();

        // Start ignored while busy; operand changes after acceptance ignored.
        start_i = 1'b1; op_i = 2'd1; src1_i = 32'd50; src2_i = 32'd5;
        tick();
        dones = 0; s_hi = 32'd0; s_lo = 32'd0;
        for (int i = 1; i < 45; i++) begin
            if (i == 10) begin
                start_i = 1'b1; op_i = 2'd0; src1_i = 32'd99; src2_i = 32'd3;
            end else begin
                start_i = 1'b0;
            end
            if (i == 20) src1_i = 32'd7;
            tick();
            if (done_o === 1'b1) begin
                dones++;
                s_hi = hi_o;
                s_lo = lo_o;
            end
        end
        check("ignore_dones", dones, 32'd1);
        check("ignore_lo", s_lo, 32'd10);
        check("ignore_hi", s_hi, 32'd0);

        // Reset mid-calculation with a simultaneous start.
        start_i = 1'b1; op_i = 2'd0; src1_i = 32'd3; src2_i = 32'd4;
        tick();
        start_i = 1'b0;
        repeat (14) tick();
        rst_i = 1'b1; start_i = 1'b1;
        tick();
        rst_i = 1'b0; start_i = 1'b0;
        check("abort_busy", {31'd0, busy_o}, 32'd0);
        check("abort_hi", hi_o, 32'd0);
        check("abort_lo", lo_o, 32'd0);
        dones = 0;
        repeat (40) begin
            tick();
            if (done_o === 1'b1) dones++;
        end
        check("abort_no_done", dones, 32'd0);
        run_op(2'd0, 32'd3, 32'd4, lat);
        check("after_rst_lat", lat, 32'd34);
        check("after_rst_lo", lo_o, 32'd12);

        // Back-to-back with start held high.
        start_i = 1'b1; op_i = 2'd0; src1_i = 32'd5; src2_i = 32'd6;
        for (int i = 1; i <= 110; i++) begin
            tick();
            if (done_o === 1'b1) begin
                t_done.push_back(i);
                src1_i = src1_i + 32'd1;
            end
        end
        start_i = 1'b0;
        check("b2b_count", t_done.size(), 32'd3);
        if (t_done.size() == 3) begin
            check("b2b_first", t_done[0], 32'd34);
            check("b2b_gap1", t_done[1] - t_done[0], 32'd34);
            check("b2b_gap2", t_done[2] - t_done[1], 32'd34);
        end
        lat = 0;
        while (busy_o !== 1'b0 && lat < 40) begin
            tick();
            lat++;
        end
        check("drain_idle", {31'd0, busy_o}, 32'd0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
